// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle RV32I control path:
//            opcodes, FSM state encodings and datapath mux select codes.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

   // RV32I major opcodes (IR[6:0])
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_I_LD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_SB   = 7'b1100011;
   localparam logic [6:0] OP_J    = 7'b1101111;
   localparam logic [6:0] OP_J_R  = 7'b1100111;

   // Controller states; the encoding is visible on state_dbg
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_WB_ALU   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR     = 4'd11,
      ST_ILLEGAL  = 4'd12
   } state_t;

   // ALU operand A select
   localparam logic [1:0] ALU_A_PC     = 2'd0;
   localparam logic [1:0] ALU_A_OLDPC  = 2'd1;
   localparam logic [1:0] ALU_A_REG    = 2'd2;

   // ALU operand B select
   localparam logic [1:0] ALU_B_REG    = 2'd0;
   localparam logic [1:0] ALU_B_FOUR   = 2'd1;
   localparam logic [1:0] ALU_B_IMM    = 2'd2;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   // Register write-back select
   localparam logic [1:0] MTR_ALUOUT   = 2'd0;
   localparam logic [1:0] MTR_MDR      = 2'd1;
   localparam logic [1:0] MTR_PC       = 2'd2;

   // PC input select
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_op_class.sv
`default_nettype none
// ============================================================================
// Module   : mc_op_class
// Purpose  : Combinational opcode classifier giving the state that follows
//            DECODE. Kept separate so the pipelined hazard unit can reuse it.
// Revision : 1.0 - initial release
// ============================================================================
module mc_op_class
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output state_t     next_state
);

   // Map each supported major opcode to its first execution state
   always_comb begin
      next_state = ST_ILLEGAL;
      case (opcode)
         OP_R:         next_state = ST_EXEC_R;
         OP_I:         next_state = ST_EXEC_I;
         OP_I_LD,
         OP_S:         next_state = ST_MEM_ADDR;
         OP_SB:        next_state = ST_BRANCH;
         OP_J:         next_state = ST_JAL;
         OP_J_R:       next_state = ST_JALR;
         default:      next_state = ST_ILLEGAL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Moore control FSM for the multi-cycle RV32I core. Steps the
//            shared ALU, unified memory port and register file through each
//            instruction, with a req/ready handshake on memory.
// Options  : MCCTRL_ILLEGAL_TRAP_EN - ILLEGAL becomes a sink state that drives
//            illegal_instr; otherwise an illegal opcode behaves as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic       regwrite,
   output logic [1:0] memtoreg,
`ifdef MCCTRL_ILLEGAL_TRAP_EN
   output logic       illegal_instr,
`endif
   output logic [3:0] state_dbg
);

   state_t r_state;
   state_t w_next;
   state_t w_decode_next;

   mc_op_class u_op_class (
      .opcode     (opcode),
      .next_state (w_decode_next)
   );

   // State register; reset returns the sequencer to FETCH
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and Moore outputs; reset blanks every output combinationally
   // so an outstanding memory request drops in the same cycle
   always_comb begin
      w_next        = r_state;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PCSRC_ALU;
      alu_src_a     = ALU_A_PC;
      alu_src_b     = ALU_B_REG;
      aluop         = ALUOP_ADD;
      regwrite      = 1'b0;
      memtoreg      = MTR_ALUOUT;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
      state_dbg     = r_state;

      case (r_state)
         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = ALU_B_FOUR;
            // IR load and PC+4 happen only in the cycle the fetch completes
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_src_a = ALU_A_OLDPC;
            alu_src_b = ALU_B_IMM;
            w_next    = w_decode_next;
         end
         ST_EXEC_R: begin
            alu_src_a = ALU_A_REG;
            aluop     = ALUOP_FUNCT;
            w_next    = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            alu_src_a = ALU_A_REG;
            alu_src_b = ALU_B_IMM;
            aluop     = ALUOP_FUNCT;
            w_next    = ST_WB_ALU;
         end
         ST_MEM_ADDR: begin
            alu_src_a = ALU_A_REG;
            alu_src_b = ALU_B_IMM;
            // Only loads and stores reach here, so anything not a store reads
            w_next    = (opcode == OP_S) ? ST_MEM_WR : ST_MEM_RD;
         end
         ST_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               w_next = ST_WB_MEM;
            end
         end
         ST_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               w_next = ST_FETCH;
            end
         end
         ST_WB_ALU: begin
            regwrite = 1'b1;
            w_next   = ST_FETCH;
         end
         ST_WB_MEM: begin
            regwrite = 1'b1;
            memtoreg = MTR_MDR;
            w_next   = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a     = ALU_A_REG;
            aluop         = ALUOP_BRANCH;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_ALUOUT;
            w_next        = ST_FETCH;
         end
         ST_JAL: begin
            regwrite = 1'b1;
            memtoreg = MTR_PC;
            pc_write = 1'b1;
            pc_src   = PCSRC_ALUOUT;
            w_next   = ST_FETCH;
         end
         ST_JALR: begin
            alu_src_a = ALU_A_REG;
            alu_src_b = ALU_B_IMM;
            pc_write  = 1'b1;
            regwrite  = 1'b1;
            memtoreg  = MTR_PC;
            w_next    = ST_FETCH;
         end
         ST_ILLEGAL: begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            illegal_instr = 1'b1;
            w_next        = ST_ILLEGAL;
`else
            // PC was already advanced in FETCH, so simply move on
            w_next        = ST_FETCH;
`endif
         end
         default: begin
            w_next = ST_FETCH;
         end
      endcase

      if (!rst_n) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         iord          = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_src        = 1'b0;
         alu_src_a     = 2'd0;
         alu_src_b     = 2'd0;
         aluop         = 2'd0;
         regwrite      = 1'b0;
         memtoreg      = 2'd0;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         illegal_instr = 1'b0;
`endif
         state_dbg     = ST_FETCH;
         w_next        = ST_FETCH;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Instruction scripts of
//            (expected state, mem_ready) are expanded per cycle; expected
//            output vectors go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       illegal;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] aluop;
      logic       regwrite;
      logic [1:0] memtoreg;
   } outs_t;

   typedef struct packed {
      logic [3:0] st;
      outs_t      outs;
   } exp_t;

   typedef struct packed {
      logic [6:0] op;
      logic [3:0] st;
      logic       rdy;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
   logic [1:0] alu_src_a, alu_src_b, aluop, memtoreg;
   logic       regwrite, illegal_instr;
   logic [3:0] state_dbg;
   outs_t      act;

   stim_t stim_q[$];
   exp_t  sb_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .aluop         (aluop),
      .regwrite      (regwrite),
      .memtoreg      (memtoreg),
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      .illegal_instr (illegal_instr),
`endif
      .state_dbg     (state_dbg)
   );

`ifndef MCCTRL_ILLEGAL_TRAP_EN
   assign illegal_instr = 1'b0;
`endif

   always_comb begin
      act = '{illegal_instr, mem_req, mem_we, iord, ir_write, pc_write,
              pc_write_cond, pc_src, alu_src_a, alu_src_b, aluop, regwrite, memtoreg};
   end

   // Reference outputs for a state, written from the state table
   function automatic outs_t model(input logic [3:0] st, input logic rdy);
      outs_t o = '0;
      case (st)
         ST_FETCH:    begin o.mem_req = 1; o.b = 2'd1; o.ir_write = rdy; o.pc_write = rdy; end
         ST_DECODE:   begin o.a = 2'd1; o.b = 2'd2; end
         ST_EXEC_R:   begin o.a = 2'd2; o.b = 2'd0; o.aluop = 2'b10; end
         ST_EXEC_I:   begin o.a = 2'd2; o.b = 2'd2; o.aluop = 2'b10; end
         ST_MEM_ADDR: begin o.a = 2'd2; o.b = 2'd2; end
         ST_MEM_RD:   begin o.mem_req = 1; o.iord = 1; end
         ST_MEM_WR:   begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; end
         ST_WB_ALU:   begin o.regwrite = 1; end
         ST_WB_MEM:   begin o.regwrite = 1; o.memtoreg = 2'd1; end
         ST_BRANCH:   begin o.a = 2'd2; o.aluop = 2'b01; o.pc_write_cond = 1; o.pc_src = 1; end
         ST_JAL:      begin o.regwrite = 1; o.memtoreg = 2'd2; o.pc_write = 1; o.pc_src = 1; end
         ST_JALR:     begin o.a = 2'd2; o.b = 2'd2; o.pc_write = 1; o.regwrite = 1; o.memtoreg = 2'd2; end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         ST_ILLEGAL:  begin o.illegal = 1; end
`endif
         default:     o = '0;
      endcase
      return o;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expand one instruction into its expected per-cycle script
   task automatic plan(input logic [6:0] op, input int fwaits, input int mwaits);
      for (int i = 0; i < fwaits; i++) stim_q.push_back('{op, ST_FETCH, 1'b0});
      stim_q.push_back('{op, ST_FETCH, 1'b1});
      stim_q.push_back('{op, ST_DECODE, rnd()});
      case (op)
         OP_R:    begin stim_q.push_back('{op, ST_EXEC_R, rnd()}); stim_q.push_back('{op, ST_WB_ALU, rnd()}); end
         OP_I:    begin stim_q.push_back('{op, ST_EXEC_I, rnd()}); stim_q.push_back('{op, ST_WB_ALU, rnd()}); end
         OP_I_LD: begin
            stim_q.push_back('{op, ST_MEM_ADDR, rnd()});
            for (int i = 0; i < mwaits; i++) stim_q.push_back('{op, ST_MEM_RD, 1'b0});
            stim_q.push_back('{op, ST_MEM_RD, 1'b1});
            stim_q.push_back('{op, ST_WB_MEM, rnd()});
         end
         OP_S: begin
            stim_q.push_back('{op, ST_MEM_ADDR, rnd()});
            for (int i = 0; i < mwaits; i++) stim_q.push_back('{op, ST_MEM_WR, 1'b0});
            stim_q.push_back('{op, ST_MEM_WR, 1'b1});
         end
         OP_SB:   stim_q.push_back('{op, ST_BRANCH, rnd()});
         OP_J:    stim_q.push_back('{op, ST_JAL, rnd()});
         OP_J_R:  stim_q.push_back('{op, ST_JALR, rnd()});
         default: stim_q.push_back('{op, ST_ILLEGAL, rnd()});
      endcase
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (act !== '0 || state_dbg !== 4'(ST_FETCH)) begin
            n_err++;
            $display("FAIL reset: outs=%h state=%0d required outs=0 state=%0d", act, state_dbg, ST_FETCH);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b0;
   endtask

   task automatic test_alu();
      stim_t s;
      exp_t  e;
      plan(OP_R, 0, 0);
      plan(OP_I, 1, 0);
      stim_q.push_back('{OP_I, ST_FETCH, 1'b0});
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL alu: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
   endtask

   task automatic test_load_store();
      stim_t s;
      exp_t  e;
      plan(OP_I_LD, 0, 2);
      plan(OP_S, 0, 0);
      plan(OP_S, 0, 3);
      stim_q.push_back('{OP_S, ST_FETCH, 1'b0});
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL load_store: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
   endtask

   task automatic test_branch_jumps();
      stim_t s;
      exp_t  e;
      plan(OP_SB, 0, 0);
      plan(OP_J, 0, 0);
      plan(OP_J_R, 2, 0);
      stim_q.push_back('{OP_J_R, ST_FETCH, 1'b0});
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL branch_jumps: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
   endtask

   task automatic test_illegal();
      stim_t s;
      exp_t  e;
      plan(7'b0000000, 0, 0);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 5; i++) stim_q.push_back('{7'd0, ST_ILLEGAL, rnd()});
`else
      stim_q.push_back('{7'd0, ST_FETCH, 1'b0});
`endif
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL illegal: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      test_reset();
`endif
   endtask

   task automatic test_reset_mid();
      stim_t s;
      exp_t  e;
      plan(OP_I_LD, 0, 6);
      // keep only up to the first stalled MEM_RD cycle
      while (stim_q.size() > 4) void'(stim_q.pop_back());
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL reset_mid: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || act !== '0 || state_dbg !== 4'(ST_FETCH)) begin
         n_err++;
         $display("FAIL reset_mid_drop: mem_req=%b outs=%h state=%0d required mem_req=0 outs=0 state=%0d",
                  mem_req, act, state_dbg, ST_FETCH);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (state_dbg !== 4'(ST_FETCH) || act !== model(ST_FETCH, 1'b0)) begin
         n_err++;
         $display("FAIL reset_mid_restart: state=%0d outs=%h required state=%0d outs=%h",
                  state_dbg, act, ST_FETCH, model(ST_FETCH, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      exp_t  e;
      plan(OP_R, 0, 0);
      plan(OP_I_LD, 0, 0);
      plan(OP_S, 1, 1);
      plan(OP_SB, 0, 0);
      plan(7'b1111111, 0, 0);
      stim_q.push_back('{OP_R, ST_FETCH, 1'b0});
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      // the final illegal opcode would trap; swap it for a JAL
      void'(stim_q.pop_back());
      void'(stim_q.pop_back());
      stim_q.push_back('{OP_J, ST_JAL, 1'b0});
      stim_q.push_back('{OP_J, ST_FETCH, 1'b0});
      for (int i = 0; i < stim_q.size(); i++) if (stim_q[i].op == 7'b1111111) stim_q[i].op = OP_J;
`endif
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(negedge clk);
         opcode = s.op; mem_ready = s.rdy;
         sb_q.push_back('{s.st, model(s.st, s.rdy)});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (state_dbg !== e.st || act !== e.outs) begin
            n_err++;
            $display("FAIL back_to_back: state=%0d outs=%h required state=%0d outs=%h", state_dbg, act, e.st, e.outs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch_jumps();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multi-cycle RV32I core. It sequences a shared ALU, a unified instruction/data memory port and the register file over several cycles per instruction. It replaces the per-opcode combinational decode of the single-cycle core with a stepped sequence, and adds a request/ready handshake to memory. It sits between the instruction register's opcode field and the multi-cycle datapath's muxes and write enables.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = write (store), 0 = read.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the datapath's branch-taken flag is 1.
- pc_src  out  1  PC input select: 0 = ALU result, 1 = ALUOut register.
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = oldPC, 2 = reg A.
- alu_src_b  out  2  ALU B select: 0 = reg B, 1 = constant 4, 2 = immediate.
- aluop  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- regwrite  out  1  register file write enable.
- memtoreg  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC.
- illegal_instr  out  1  trap flag; exists only when MCCTRL_ILLEGAL_TRAP_EN is defined.
- state_dbg  out  4  current state encoding.

## Operation
States and the outputs each asserts; every unlisted output is 0:
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, aluop=00.
  - On mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0, so PC <= PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=1, alu_src_b=2, aluop=00, so ALUOut <= oldPC+imm. Next state by opcode:
  - R (0110011) → EXEC_R
  - I (0010011) → EXEC_I
  - I_LD (0000011) or S (0100011) → MEM_ADDR
  - SB (1100011) → BRANCH
  - J (1101111) → JAL
  - J_R (1100111) → JALR
  - any other opcode → ILLEGAL
- EXEC_R: alu_src_a=2, alu_src_b=0, aluop=10 → WB_ALU.
- EXEC_I: alu_src_a=2, alu_src_b=2, aluop=10 → WB_ALU.
- MEM_ADDR: alu_src_a=2, alu_src_b=2, aluop=00. Next state: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ready → WB_MEM; otherwise stay.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready → FETCH; otherwise stay.
- WB_ALU: regwrite=1, memtoreg=0 → FETCH.
- WB_MEM: regwrite=1, memtoreg=1 → FETCH.
- BRANCH: alu_src_a=2, alu_src_b=0, aluop=01, pc_write_cond=1, pc_src=1 → FETCH.
- JAL: regwrite=1, memtoreg=2 (rd <= PC+4), pc_write=1, pc_src=1 → FETCH.
- JALR: alu_src_a=2, alu_src_b=2, aluop=00, pc_write=1, pc_src=0, regwrite=1, memtoreg=2 → FETCH.
- ILLEGAL: behaviour is set by the Configuration section.

Rules:
- Outputs are a pure function of the current state. The one exception is ir_write/pc_write in FETCH, which are also gated by mem_ready.
- The opcode is registered by the IR, so the FSM does not latch it.

## Timing
- Reset: while rst_n=0 at a rising edge, the next state is FETCH. While rst_n=0 every output is forced to 0, including mem_req. state_dbg reads the FETCH encoding.
- Reset mid-operation: an outstanding mem_req is dropped in the same cycle rst_n goes low. A late mem_ready is ignored.
- Handshake:
  - Once mem_req rises, mem_req, mem_we and iord are held stable until the cycle in which mem_ready=1.
  - The transfer completes in that cycle.
  - mem_ready while mem_req=0 has no effect.
- Minimum cycles per instruction (mem_ready=1 on the first request cycle):
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 3
- Each wait-state cycle adds 1 to the count above.
- No output depends combinationally on opcode.

## Configuration
- MCCTRL_ILLEGAL_TRAP_EN defined:
  - ILLEGAL is a sink state: illegal_instr=1, all other outputs 0.
  - The FSM leaves ILLEGAL only on reset.
- MCCTRL_ILLEGAL_TRAP_EN undefined:
  - ILLEGAL asserts nothing for one cycle, then goes to FETCH. The instruction acts as a NOP; the PC was already advanced in FETCH.
  - The illegal_instr port is absent.

## Structure
- Package mc_ctrl_pkg holds:
  - the opcode localparams (R, I, I_LD, S, SB, J, J_R)
  - the 4-bit state encodings
  - the encodings for alu_src_a, alu_src_b, aluop, memtoreg and pc_src.
- Sub-module mc_op_class: a combinational opcode → next-state-after-DECODE decoder, shared with the future pipelined hazard unit.

## Test plan
- Reset, then R-type 0x00208033 with mem_ready=1 on every request → states FETCH, DECODE, EXEC_R, WB_ALU. regwrite=1 only in the 4th cycle, then back in FETCH.
- Load, with mem_ready held low for 2 cycles in MEM_RD → mem_req, iord=1 and mem_we=0 stay stable for 3 cycles. WB_MEM asserts memtoreg=1. Total 7 cycles.
- Store → MEM_WR asserts mem_we=1; regwrite never asserts; back in FETCH after 4 cycles.
- Branch opcode 1100011 → BRANCH asserts pc_write_cond=1, pc_src=1, aluop=01 for exactly 1 cycle; pc_write stays 0.
- JAL, then JALR → each asserts regwrite=1, memtoreg=2 and pc_write=1 in its 3rd cycle. pc_src is 1 for JAL and 0 for JALR.
- Opcode 0000000:
  - with the macro defined → illegal_instr=1 held indefinitely; cleared by rst_n=0.
  - without the macro → FETCH again after 3 cycles.
- rst_n pulsed low during MEM_RD → mem_req drops that cycle and the FSM restarts at FETCH.
